// File: rtl/mem_responder.sv
// mem_responder: responder side of the data-memory request interface.
// Accepts one request, waits LATENCY cycles, commits it to the storage array
// and returns a one-cycle ack carrying the read data.
// Optional build macro MEM_RESPONDER_RANGE_CHECK_EN: addresses >= DEPTH
// complete with err=1 and rdata=0, and their writes are suppressed. Without it,
// addresses wrap modulo DEPTH and err is tied low.
module mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_enter_resp;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [IDX_W-1:0]    w_idx;
    logic                w_oor;

    // With LATENCY=1 the commit happens on the accept edge itself, so the
    // operands come straight from the inputs while idle, else from the captured copy.
    assign w_we    = (r_state == S_IDLE) ? we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    assign w_idx   = w_addr[IDX_W-1:0];

    // Next-state logic; flags the edge on which the transaction commits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, latency counter and request capture.
    always_ff @(posedge clk or negedge init_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!init_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Read-data register: loaded on the commit edge of a read or an out-of-range access.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_rdata <= '0;
        end else if (w_enter_resp && (w_oor || !w_we)) begin
            r_rdata <= w_oor ? '0 : r_mem[w_idx];
        end
    end

    // Storage array write port; a reset in flight suppresses the pending commit.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents survive init_n by design.
        if (init_n && w_enter_resp && w_we && !w_oor) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic r_err;

    assign w_oor = (32'(w_addr) >= DEPTH);

    // Error flag rides alongside ack for the single RESP cycle.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_resp & w_oor;
        end
    end

    assign err = r_err;
`else
    assign w_oor = 1'b0;
    assign err   = 1'b0;
`endif

    assign ack   = (r_state == S_RESP);
    assign busy  = (r_state != S_IDLE);
    assign rdata = r_rdata;

endmodule
